// File: rtl/pingpong_data_buf.sv
// Ping-pong feature-map buffer: one bank fills from a write stream while the other
// serves OUT_PORT_NUM parallel registered reads. Optional macro: DBUF_ZERO_PAD_EN.
module pingpong_data_buf #(
  parameter int DEPTH        = 1024,
  parameter int WIDTH        = 16,
  parameter int ADDR_WIDTH   = 32,
  parameter int OUT_PORT_NUM = 25,
  parameter int FILL_COUNT   = DEPTH
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr_valid,
  input  logic [WIDTH-1:0]                   wr_data,
  output logic                               wr_ready,
  output logic                               wr_drop,
  output logic                               rd_bank_ready,
  input  logic                               rd_req,
  input  logic [OUT_PORT_NUM*ADDR_WIDTH-1:0] rd_addr_NP,
  output logic                               rd_valid,
  output logic [OUT_PORT_NUM*WIDTH-1:0]      rd_data_NP,
  input  logic                               rd_release,
  output logic [15:0]                        frame_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(FILL_COUNT - 1);

  logic [WIDTH-1:0] r_mem [2][DEPTH];

  logic                          r_wr_sel;
  logic                          r_rd_sel;
  logic [1:0]                    r_full;
  logic [IDX_W-1:0]              r_wr_ptr;
  logic                          r_wr_drop;
  logic [15:0]                   r_frame_cnt;
  logic                          r_rd_valid;
  logic [OUT_PORT_NUM*WIDTH-1:0] r_rd_data;

  logic             w_wr_accept;
  logic             w_wr_last;
  logic             w_rd_fire;
  logic             w_release;
  logic [1:0]       w_full_nxt;
  logic [WIDTH-1:0] w_port_data [OUT_PORT_NUM];

  assign wr_ready      = ~r_full[r_wr_sel];
  assign rd_bank_ready = r_full[r_rd_sel];
  assign wr_drop       = r_wr_drop;
  assign frame_cnt     = r_frame_cnt;
  assign rd_valid      = r_rd_valid;
  assign rd_data_NP    = r_rd_data;

  assign w_wr_accept = wr_valid & wr_ready;
  assign w_wr_last   = w_wr_accept && (r_wr_ptr == LAST_PTR);
  assign w_rd_fire   = rd_req & rd_bank_ready;
  assign w_release   = rd_release & rd_bank_ready;

  // Writes only touch an empty bank and releases only a full one, so both can apply.
  always_comb begin
    // NOTE: assign every always_comb output a default first so no latch is inferred.
    w_full_nxt = r_full;
    if (w_wr_last) w_full_nxt[r_wr_sel] = 1'b1;
    if (w_release) w_full_nxt[r_rd_sel] = 1'b0;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_sel    <= 1'b0;
      r_rd_sel    <= 1'b0;
      r_full      <= 2'b00;
      r_wr_ptr    <= '0;
      r_wr_drop   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (wr_valid && !wr_ready) r_wr_drop <= 1'b1;
      if (w_wr_last) begin
        r_wr_sel    <= ~r_wr_sel;
        r_wr_ptr    <= '0;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end else if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_release) r_rd_sel <= ~r_rd_sel;
    end
  end

  // NOTE: the storage array has no reset; contents are only read once a full frame lands.
  always_ff @(posedge clk) begin
    if (w_wr_accept) r_mem[r_wr_sel][r_wr_ptr] <= wr_data;
  end

  for (genvar gi = 0; gi < OUT_PORT_NUM; gi++) begin : g_port
    logic [ADDR_WIDTH-1:0] w_addr;
    assign w_addr = rd_addr_NP[gi*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef DBUF_ZERO_PAD_EN
    // Out-of-frame addresses read as zero to pad convolution borders.
    assign w_port_data[gi] = (w_addr >= ADDR_WIDTH'(FILL_COUNT)) ? '0
                           : r_mem[r_rd_sel][w_addr[IDX_W-1:0]];
`else
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^w_addr;
    assign w_port_data[gi]    = r_mem[r_rd_sel][w_addr[IDX_W-1:0]];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd_fire;
      if (w_rd_fire) begin
        for (int i = 0; i < OUT_PORT_NUM; i++) r_rd_data[i*WIDTH +: WIDTH] <= w_port_data[i];
      end
    end
  end

endmodule
